gemm_tile_controller: RTL and testbench

Tiled loop controller for the multi-MAC GeMM accelerator. It is the parametrised successor of the single-loop-order GeMM controller and sits between the accelerator's top-level control interface and the SRAM address generators. It latches problem sizes at start and walks M/N/K tile counters with ceiling (not truncating) tile division. It also supports a runtime-selectable outer loop order, qualifies accumulator-clear and result-valid strobes per step, and flags illegal zero-size jobs.

---
 rtl/gemm_tile_controller.sv | 162 ++++++++++++++++
 tb/tb_gemm_tile_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_controller.sv
// Tiled M/N/K loop controller for the multi-MAC GeMM accelerator, with selectable outer loop order.
// Optional performance counters are enabled by defining GEMM_PERF_CNT_EN.
module gemm_tile_controller #(
    parameter int AddrWidth = 16,
    parameter int TileM     = 4,
    parameter int TileK     = 4,
    parameter int TileN     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 input_valid_i,
    input  logic                 loop_order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
`ifdef GEMM_PERF_CNT_EN
    output logic [31:0]          stall_cycles_o,
    output logic [31:0]          step_cycles_o,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 acc_clear_o,
    output logic                 result_valid_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o
);

    localparam int CW = AddrWidth + 1;
    localparam logic [CW-1:0] LP_TILE_M     = CW'(TileM);
    localparam logic [CW-1:0] LP_TILE_K     = CW'(TileK);
    localparam logic [CW-1:0] LP_TILE_N     = CW'(TileN);
    localparam logic [CW-1:0] LP_TILE_M_M1  = CW'(TileM - 1);
    localparam logic [CW-1:0] LP_TILE_K_M1  = CW'(TileK - 1);
    localparam logic [CW-1:0] LP_TILE_N_M1  = CW'(TileN - 1);
    localparam logic [CW-1:0] LP_ONE        = CW'(1);
    localparam logic [AddrWidth-1:0] LP_CNT_ONE = AddrWidth'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_mt, r_kt, r_nt;
    logic [AddrWidth-1:0] r_m, r_k, r_n;
    logic                 r_order;
    logic                 r_err;

    logic [CW-1:0] w_mt, w_kt, w_nt;
    logic          w_size_zero;
    logic          w_m_last, w_k_last, w_n_last;
    logic          w_step, w_final;

    // Ceiling division done one bit wider so size+Tile-1 cannot overflow.
    assign w_mt = ({1'b0, M_size_i} + LP_TILE_M_M1) / LP_TILE_M;
    assign w_kt = ({1'b0, K_size_i} + LP_TILE_K_M1) / LP_TILE_K;
    assign w_nt = ({1'b0, N_size_i} + LP_TILE_N_M1) / LP_TILE_N;

    assign w_size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

    assign w_m_last = ({1'b0, r_m} == (r_mt - LP_ONE));
    assign w_k_last = ({1'b0, r_k} == (r_kt - LP_ONE));
    assign w_n_last = ({1'b0, r_n} == (r_nt - LP_ONE));

    assign w_step  = (r_state == S_BUSY) && input_valid_i;
    assign w_final = w_step && w_m_last && w_k_last && w_n_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_mt    <= '0;
            r_kt    <= '0;
            r_nt    <= '0;
            r_m     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_order <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_size_zero) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mt    <= w_mt;
                            r_kt    <= w_kt;
                            r_nt    <= w_nt;
                            r_order <= loop_order_i;
                            r_m     <= '0;
                            r_k     <= '0;
                            r_n     <= '0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_final) begin
                        r_state <= S_FINISH;
                    end else if (w_step) begin
                        r_k <= w_k_last ? '0 : r_k + LP_CNT_ONE;
                        // K is always innermost; the middle loop wraps into the outer one.
                        if (!r_order) begin
                            if (w_k_last) begin
                                r_n <= w_n_last ? '0 : r_n + LP_CNT_ONE;
                                if (w_n_last) r_m <= r_m + LP_CNT_ONE;
                            end
                        end else begin
                            if (w_k_last) begin
                                r_m <= w_m_last ? '0 : r_m + LP_CNT_ONE;
                                if (w_m_last) r_n <= r_n + LP_CNT_ONE;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    r_m     <= '0;
                    r_k     <= '0;
                    r_n     <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GEMM_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_step_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_step_cnt  <= '0;
        end else if ((r_state == S_IDLE) && start_i && !w_size_zero) begin
            r_stall_cnt <= '0;
            r_step_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            if (input_valid_i && (r_step_cnt != '1))
                r_step_cnt <= r_step_cnt + 32'd1;
            if (!input_valid_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = rst_i ? '0 : r_stall_cnt;
    assign step_cycles_o  = rst_i ? '0 : r_step_cnt;
`endif

    // Outputs are forced low while reset is held, since the state only clears on the edge.
    assign busy_o         = !rst_i && ((r_state == S_BUSY) || (r_state == S_FINISH));
    assign done_o         = !rst_i && (r_state == S_FINISH);
    assign err_o          = !rst_i && r_err;
    assign acc_clear_o    = !rst_i && w_step && (r_k == '0);
    assign result_valid_o = !rst_i && w_step && w_k_last;
    assign M_count_o      = rst_i ? '0 : r_m;
    assign K_count_o      = rst_i ? '0 : r_k;
    assign N_count_o      = rst_i ? '0 : r_n;

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Directed self-checking bench for gemm_tile_controller (default tile sizes 4x4x4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_gemm_tile_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        input_valid_i = 1'b0;
    logic        loop_order_i = 1'b0;
    logic [15:0] M_size_i = '0;
    logic [15:0] K_size_i = '0;
    logic [15:0] N_size_i = '0;
    logic        busy_o, done_o, err_o, acc_clear_o, result_valid_o;
    logic [15:0] M_count_o, K_count_o, N_count_o;
`ifdef GEMM_PERF_CNT_EN
    logic [31:0] stall_cycles_o, step_cycles_o;
`endif

    int errors = 0;
    int checks = 0;

    gemm_tile_controller #(.AddrWidth(16), .TileM(4), .TileK(4), .TileN(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .input_valid_i  (input_valid_i),
        .loop_order_i   (loop_order_i),
        .M_size_i       (M_size_i),
        .K_size_i       (K_size_i),
        .N_size_i       (N_size_i),
`ifdef GEMM_PERF_CNT_EN
        .stall_cycles_o (stall_cycles_o),
        .step_cycles_o  (step_cycles_o),
`endif
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .acc_clear_o    (acc_clear_o),
        .result_valid_o (result_valid_o),
        .M_count_o      (M_count_o),
        .K_count_o      (K_count_o),
        .N_count_o      (N_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic do_start(input int m, input int k, input int n, input logic ord, input logic v);
        @(negedge clk_i);
        start_i       = 1'b1;
        M_size_i      = 16'(m);
        K_size_i      = 16'(k);
        N_size_i      = 16'(n);
        loop_order_i  = ord;
        input_valid_i = v;
    endtask

    task automatic test_reset;
        logic [52:0] obs;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            rst_i         = (c < 2);
            input_valid_i = 1'b1;
            start_i       = 1'b0;
            #1;
            obs = {busy_o, done_o, err_o, acc_clear_o, result_valid_o, M_count_o, K_count_o, N_count_o};
            checks++;
            if (obs !== 53'd0) begin
                errors++;
                $display("[TB] FAIL reset_cycle%0d: got %h expected 0", c, obs);
            end
        end
    endtask

    task automatic test_base_order0;
        logic [50:0] obs, exp;
        do_start(8, 8, 8, 1'b0, 1'b1);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL base_start_busy: got %b expected 0", busy_o);
        end
        for (int s = 0; s < 8; s++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            obs = {busy_o, M_count_o, N_count_o, K_count_o, acc_clear_o, result_valid_o};
            exp = {1'b1, 16'(s / 4), 16'((s / 2) % 2), 16'(s % 2), (s % 2) == 0, (s % 2) == 1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL base_step%0d: got %h expected %h", s, obs, exp);
            end
        end
        @(negedge clk_i);
        #1;
        obs = {busy_o, M_count_o, N_count_o, K_count_o, acc_clear_o, result_valid_o};
        exp = {1'b1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp || done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL base_finish: got %h done=%b expected %h done=1", obs, done_o, exp);
        end
        @(negedge clk_i);
        #1;
        obs = {busy_o, M_count_o, N_count_o, K_count_o, acc_clear_o, result_valid_o};
        checks++;
        if (obs !== 51'd0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL base_idle: got %h done=%b expected 0", obs, done_o);
        end
    endtask

    task automatic test_ceiling;
        logic [51:0] obs, exp;
        // start_i stays high and sizes go to zero during the job; neither may disturb it
        do_start(5, 4, 9, 1'b0, 1'b1);
        for (int s = 0; s < 6; s++) begin
            @(negedge clk_i);
            M_size_i = '0;
            K_size_i = '0;
            N_size_i = '0;
            loop_order_i = 1'b1;
            #1;
            obs = {busy_o, err_o, M_count_o, N_count_o, K_count_o, acc_clear_o, result_valid_o};
            exp = {1'b1, 1'b0, 16'(s / 3), 16'(s % 3), 16'd0, 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL ceil_step%0d: got %h expected %h", s, obs, exp);
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b1 || M_count_o !== 16'd1 || N_count_o !== 16'd2) begin
            errors++;
            $display("[TB] FAIL ceil_done: got done=%b M=%0d N=%0d expected done=1 M=1 N=2",
                     done_o, M_count_o, N_count_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_order1;
        logic [49:0] obs, exp;
        do_start(8, 4, 8, 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            loop_order_i = 1'b0;
            #1;
            obs = {busy_o, M_count_o, N_count_o, K_count_o, done_o};
            exp = {1'b1, 16'(s % 2), 16'(s / 2), 16'd0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL order1_step%0d: got %h expected %h", s, obs, exp);
            end
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL order1_done: got %b expected 1", done_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_stalls;
        logic [50:0] obs, exp;
        int s = 0;
        logic v;
        do_start(8, 8, 8, 1'b0, 1'b1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            v = (j % 2) == 1;
            input_valid_i = v;
            #1;
            obs = {busy_o, M_count_o, N_count_o, K_count_o, acc_clear_o, result_valid_o};
            exp = {1'b1, 16'(s / 4), 16'((s / 2) % 2), 16'(s % 2), v && (s % 2) == 0, v && (s % 2) == 1};
            checks++;
            if (obs !== exp || done_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: got %h done=%b expected %h done=0", j, obs, done_o, exp);
            end
            if (v) s++;
        end
        @(negedge clk_i);
        input_valid_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done: got %b expected 1", done_o);
        end
`ifdef GEMM_PERF_CNT_EN
        @(negedge clk_i);
        #1;
        checks++;
        if (stall_cycles_o !== 32'd8 || step_cycles_o !== 32'd8) begin
            errors++;
            $display("[TB] FAIL stall_perf: got stall=%0d step=%0d expected 8/8", stall_cycles_o, step_cycles_o);
        end
`else
        @(negedge clk_i);
`endif
    endtask

    task automatic test_zero_size;
        do_start(8, 0, 8, 1'b0, 1'b0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_err: got err=%b busy=%b expected err=1 busy=0", err_o, busy_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after: got err=%b busy=%b expected 0 0", err_o, busy_o);
        end
        do_start(4, 4, 4, 1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, acc_clear_o, result_valid_o, err_o} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL zero_retry: got %b expected 1110", {busy_o, acc_clear_o, result_valid_o, err_o});
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_retry_done: got %b expected 1", done_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back;
        logic [3:0] obs;
        do_start(4, 4, 4, 1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        do_start(4, 8, 4, 1'b0, 1'b1);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            obs = {busy_o, done_o, acc_clear_o, result_valid_o};
            checks++;
            if (obs !== ((s == 0) ? 4'b1010 : (s == 1) ? 4'b1001 : 4'b1100)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", s, obs,
                         (s == 0) ? 4'b1010 : (s == 1) ? 4'b1001 : 4'b1100);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_job;
        logic [52:0] obs;
        int steps = 0;
        logic seen_done = 1'b0;
        do_start(8, 8, 8, 1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            obs = {busy_o, done_o, err_o, acc_clear_o, result_valid_o, M_count_o, K_count_o, N_count_o};
            checks++;
            if (obs !== 53'd0) begin
                errors++;
                $display("[TB] FAIL midreset_cycle%0d: got %h expected 0", c, obs);
            end
            @(negedge clk_i);
            rst_i = 1'b0;
        end
        do_start(8, 8, 8, 1'b0, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, M_count_o, N_count_o, K_count_o} !== {1'b1, 48'd0}) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got busy=%b M=%0d N=%0d K=%0d expected 1 0 0 0",
                     busy_o, M_count_o, N_count_o, K_count_o);
        end
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (done_o) seen_done = 1'b1;
            else if (busy_o) steps++;
            if (!seen_done) begin
                @(negedge clk_i);
                #1;
            end
        end
        checks++;
        if (!seen_done || steps != 8) begin
            errors++;
            $display("[TB] FAIL midreset_job: got done=%b steps=%0d expected done=1 steps=8", seen_done, steps);
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset;
        test_base_order0;
        test_ceiling;
        test_order1;
        test_stalls;
        test_zero_size;
        test_back_to_back;
        test_reset_mid_job;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
